// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_HIGH = 2'd1,
        CAP_LOW  = 2'd2
    } pwm_cap_state_t;

    localparam int unsigned PWM_CAP_CNT_W   = 22;
    localparam int unsigned PWM_CAP_TIMEOUT = 4_000_000;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus a delay flop; yields the clean level and its edge strobes.
module pwm_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;

    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign pwm_s = sync2_q;
    assign rise  = sync2_q & ~dly_q;
    assign fall  = ~sync2_q & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM signal, with a no-edge timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = PWM_CAP_CNT_W,
    parameter int unsigned TIMEOUT_CYC = PWM_CAP_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic pwm_s;
    logic rise;
    logic fall;

    pwm_edge_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pwm_in  (pwm_in),
        .pwm_s   (pwm_s),
        .rise    (rise),
        .fall    (fall)
    );

    pwm_cap_state_t   state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] hi_lat_q,     hi_lat_d;
    logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q,      valid_d;
    logic             timeout_q,    timeout_d;
    logic             level_q,      level_d;
    logic             at_limit;

    assign at_limit = (cnt_q == CNT_LIMIT);

    // A rise always restarts the count and beats a simultaneous timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_lat_d     = hi_lat_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;
        level_d      = level_q;

        if (!en) begin
            state_d = CAP_IDLE;
            cnt_d   = '0;
        end else begin
            if (rise) begin
                cnt_d = CNT_ONE;
            end else if (!at_limit) begin
                cnt_d = cnt_q + CNT_ONE;
            end

            if (rise) begin
                timeout_d = 1'b0;
                state_d   = CAP_HIGH;
                if (state_q == CAP_LOW) begin
                    high_cnt_d   = hi_lat_q;
                    period_cnt_d = cnt_q;
                    valid_d      = 1'b1;
                end
            end else if (at_limit) begin
                timeout_d = 1'b1;
                level_d   = pwm_s;
                state_d   = CAP_IDLE;
            end else if (fall && (state_q == CAP_HIGH)) begin
                hi_lat_d = cnt_q;
                state_d  = CAP_LOW;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CAP_IDLE;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            level_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            level_q      <= level_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign level      = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a waveform model predicts each published measurement.
module tb_pwm_capture;

    localparam int CNT_W = 16;
    localparam int TO    = 5000;
    localparam int LAT   = 3;

    logic             clk;
    logic             reset_n;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             valid;
    logic             timeout;
    logic             level;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .valid      (valid),
        .timeout    (timeout),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int per;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;
    int   cyc;

    // Model of the waveform as seen by the capture block
    logic m_prev;
    logic m_armed;
    logic m_have_fall;
    logic m_en;
    int   m_rise;
    int   m_fall;

    task automatic model_reset();
        sb_q.delete();
        m_prev      = 1'b0;
        m_armed     = 1'b0;
        m_have_fall = 1'b0;
        m_en        = en;
        m_rise      = cyc;
        m_fall      = cyc;
    endtask

    // One clock slot: service the scoreboard on the sampled outputs, then drive the next input level.
    task automatic step(input logic v);
        exp_t e;
        logic rise_now;
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_valid cyc=%0d high_cnt=%0d period_cnt=%0d, none expected",
                         cyc, high_cnt, period_cnt);
            end else begin
                e = sb_q.pop_front();
                if (high_cnt !== CNT_W'(e.hi) || period_cnt !== CNT_W'(e.per) || cyc != e.due) begin
                    tests_failed++;
                    $display("FAIL measurement cyc=%0d high=%0d period=%0d, expected cyc=%0d high=%0d period=%0d",
                             cyc, high_cnt, period_cnt, e.due, e.hi, e.per);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL missing_valid cyc=%0d valid=%b, expected valid at cyc=%0d high=%0d period=%0d",
                     cyc, valid, e.due, e.hi, e.per);
        end

        pwm_in   = v;
        rise_now = v && !m_prev;
        if (rise_now) begin
            if (m_en) begin
                if (m_armed && m_have_fall) begin
                    e.hi  = m_fall - m_rise;
                    e.per = cyc - m_rise;
                    e.due = cyc + LAT;
                    sb_q.push_back(e);
                end
                m_armed = 1'b1;
            end
            m_rise      = cyc;
            m_have_fall = 1'b0;
        end else begin
            if (!v && m_prev) begin
                m_fall      = cyc;
                m_have_fall = 1'b1;
            end
            if (m_armed && (cyc - m_rise) >= TO) begin
                m_armed     = 1'b0;
                m_have_fall = 1'b0;
            end
        end
        if (!m_en) m_armed = 1'b0;
        m_prev = v;
    endtask

    task automatic run_wave(input int h, input int p, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++)
                step(i < h);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        en      = 1'b1;
        pwm_in  = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if (high_cnt !== '0) begin tests_failed++; $display("FAIL reset_high_cnt got=%0d exp=0", high_cnt); end
        tests_run++;
        if (period_cnt !== '0) begin tests_failed++; $display("FAIL reset_period_cnt got=%0d exp=0", period_cnt); end
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", valid); end
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        tests_run++;
        if (level !== 1'b0) begin tests_failed++; $display("FAIL reset_level got=%b exp=0", level); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        run_wave(300, 1000, 4);
        repeat (LAT + 1) step(m_prev);
        tests_run++;
        if (sb_q.size() != 0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drain pending=%0d timeout=%b, expected 0 pending and timeout=0", sb_q.size(), timeout);
        end
    endtask

    task automatic test_servo();
        run_wave(375, 4800, 2);
        step(1'b1);
        repeat (LAT + 1) step(1'b0);
        tests_run++;
        if (high_cnt !== CNT_W'(375) || period_cnt !== CNT_W'(4800) || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL servo_result high=%0d period=%0d timeout=%b, expected 375 4800 0", high_cnt, period_cnt, timeout);
        end
    endtask

    task automatic test_period_at_limit();
        run_wave(1, TO, 2);
        step(1'b1);
        repeat (LAT + 1) step(1'b0);
        tests_run++;
        if (period_cnt !== CNT_W'(TO) || high_cnt !== CNT_W'(1) || timeout !== 1'b0 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL limit_period high=%0d period=%0d timeout=%b pending=%0d, expected 1 %0d 0 0",
                     high_cnt, period_cnt, timeout, sb_q.size(), TO);
        end
    endtask

    task automatic test_narrow();
        run_wave(1, 2, 10);
        repeat (LAT + 1) step(1'b0);
        tests_run++;
        if (high_cnt !== CNT_W'(1) || period_cnt !== CNT_W'(2) || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL narrow high=%0d period=%0d pending=%0d, expected 1 2 0", high_cnt, period_cnt, sb_q.size());
        end
    endtask

    task automatic test_stuck(input logic lvl);
        int r;
        int s;
        run_wave(300, 1000, 2);
        if (lvl) step(1'b1);
        r = m_rise;
        while (cyc < r + TO + 2) step(lvl);
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early lvl=%b cyc=%0d timeout=%b exp=0", lvl, cyc, timeout);
        end
        step(lvl);
        tests_run++;
        if (timeout !== 1'b1 || level !== lvl) begin
            tests_failed++;
            $display("FAIL timeout_assert lvl=%b cyc=%0d timeout=%b level=%b, expected 1 %b", lvl, cyc, timeout, level, lvl);
        end
        repeat (20) step(lvl);
        if (lvl) repeat (20) step(1'b0);
        step(1'b1);
        s = cyc;
        step(1'b1);
        step(1'b1);
        tests_run++;
        if (timeout !== 1'b1 || cyc != s + 2) begin
            tests_failed++;
            $display("FAIL timeout_hold cyc=%0d timeout=%b, expected 1 before clear", cyc, timeout);
        end
        step(1'b1);
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear cyc=%0d timeout=%b exp=0", cyc, timeout);
        end
        repeat (296) step(1'b1);
        repeat (700) step(1'b0);
        run_wave(300, 1000, 2);
        repeat (LAT + 1) step(1'b0);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stuck_drain pending=%0d exp=0", sb_q.size());
        end
    endtask

    task automatic test_enable();
        run_wave(300, 1000, 2);
        repeat (100) step(1'b1);
        en   = 1'b0;
        m_en = 1'b0;
        repeat (200) step(1'b1);
        repeat (700) step(1'b0);
        run_wave(300, 1000, 1);
        repeat (250) step(1'b0);
        tests_run++;
        if (high_cnt !== CNT_W'(300) || period_cnt !== CNT_W'(1000) || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_hold high=%0d period=%0d timeout=%b, expected 300 1000 0", high_cnt, period_cnt, timeout);
        end
        en   = 1'b1;
        m_en = 1'b1;
        repeat (250) step(1'b0);
        run_wave(300, 1000, 3);
        repeat (LAT + 1) step(1'b0);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL enable_drain pending=%0d exp=0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        run_wave(300, 1000, 1);
        repeat (100) step(1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        pwm_in = 1'b0;
        #1;
        tests_run++;
        if (high_cnt !== '0 || period_cnt !== '0 || valid !== 1'b0 || timeout !== 1'b0 || level !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid high=%0d period=%0d valid=%b timeout=%b level=%b, expected all 0",
                     high_cnt, period_cnt, valid, timeout, level);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run_wave(400, 900, 3);
        repeat (LAT + 1) step(1'b0);
        tests_run++;
        if (sb_q.size() != 0 || high_cnt !== CNT_W'(400) || period_cnt !== CNT_W'(900)) begin
            tests_failed++;
            $display("FAIL reset_mid_resume pending=%0d high=%0d period=%0d, expected 0 400 900",
                     sb_q.size(), high_cnt, period_cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        test_reset();
        test_basic();
        test_servo();
        test_period_at_limit();
        test_narrow();
        test_stuck(1'b1);
        test_stuck(1'b0);
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform (servo command, external LED dimmer, or loop-back of our own generator outputs) and reports its high time and period in clock cycles. It is the receive-side counterpart of the PWM generator top: one `pwm_in` pin comes in, and a measurement word with a one-cycle `valid` strobe goes out once per PWM period. A timeout flags a missing signal and identifies 0 %/100 % duty.

## Interface
- `CNT_W`, 22: width of the internal counter and of the result outputs. 2^22 cycles is about 33.5 ms at 125 MHz.
- `TIMEOUT_CYC`, 4_000_000: number of cycles without a rising edge before `timeout` asserts. Must be ≤ 2^CNT_W − 1.
- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  measurement enable. Low forces IDLE and clears the counter.
- `pwm_in`  in  1  PWM input, asynchronous to `clk`.
- `high_cnt`  out  CNT_W  high time of the last complete period, in cycles.
- `period_cnt`  out  CNT_W  rising-edge-to-rising-edge time of the last complete period, in cycles.
- `valid`  out  1  one-cycle pulse when `high_cnt`/`period_cnt` update.
- `timeout`  out  1  no rising edge seen for `TIMEOUT_CYC` cycles.
- `level`  out  1  synchronized input level, captured when `timeout` asserts.

## Operation
- **Synchronizer:** `pwm_in` passes through two flops to give `pwm_s`. A third flop gives `pwm_d`.
  - `rise` = `pwm_s & ~pwm_d`
  - `fall` = `~pwm_s & pwm_d`
- **Counter `cnt`:**
  - On `rise`, `cnt` ← 1.
  - Otherwise it increments, saturating at `TIMEOUT_CYC`.
  - On `en`=0, `cnt` ← 0.
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE, on `rise`: go to HIGH. No measurement is published, because the first edge only arms the block.
  - HIGH, on `fall`: `hi_lat` ← `cnt`, go to LOW.
  - LOW, on `rise`:
    - `high_cnt` ← `hi_lat`, `period_cnt` ← `cnt`, `valid` ← 1.
    - Go to HIGH.
  - Any state, when `cnt` == `TIMEOUT_CYC` and not `rise`:
    - `timeout` ← 1, `level` ← `pwm_s`, go to IDLE.
    - `high_cnt` and `period_cnt` hold.
  - `timeout` clears on the next `rise`.
  - `en`=0: go to IDLE, `cnt` ← 0, `valid` ← 0. `timeout`, `level` and the results hold.
- **Result semantics:** with `pwm_s` high for H cycles of a P-cycle period, `high_cnt` = H and `period_cnt` = P, exactly.
- **Width rule:** results are unsigned CNT_W. `cnt` never exceeds `TIMEOUT_CYC`, so no wrap-around is possible.
- **Simultaneous `rise` and `cnt` == `TIMEOUT_CYC`:** the `rise` wins. No timeout fires, and the measurement is published if the block was in LOW.
- **`fall` in IDLE or LOW:** ignored. **`rise` in HIGH:** cannot occur, because `fall` must come first.

## Timing
- **Reset:** everything clears immediately and asynchronously.
  - `high_cnt`=0, `period_cnt`=0, `valid`=0, `timeout`=0, `level`=0.
  - State IDLE, `cnt`=0, all synchronizer flops 0.
- **Latency:** a `pwm_in` rising edge set up before clk edge k gives `rise` in the cycle after edge k+1, and `valid` high after edge k+2. Total: 3 cycles.
- **Result timing:** `high_cnt` and `period_cnt` change on the same edge that raises `valid` and are stable until the next `valid`.
- **First result:** after reset, `en` rising, or a timeout, the first `valid` appears one full period after the first `rise`, i.e. on the second rising edge.
- **Minimum measurable waveform:** H=1, P=2. Pulses shorter than one clock may be missed.
- **`timeout` assertion:** `timeout` is registered and asserts on the edge after `cnt` reaches `TIMEOUT_CYC`.

## Structure
- **Shared package `pwm_pkg`:**
  - `typedef enum logic [1:0] {CAP_IDLE, CAP_HIGH, CAP_LOW} pwm_cap_state_t`
  - Constants `PWM_CAP_CNT_W` = 22 and `PWM_CAP_TIMEOUT` = 4_000_000, for use by `pwm_top`-level instantiation.
- **Sub-module `pwm_edge_sync`:** two-flop synchronizer plus delay flop, outputs `pwm_s`, `rise` and `fall`. It is reusable for switch inputs.
- **Top of this block:** counter, FSM and output registers.

## Test plan
- **Reset:** assert `reset_n`=0 mid-stream → all outputs 0 within the same cycle. Release → no `valid` until the second `rise`.
- **Basic duty:** synchronous stimulus, high 300 / period 1000 cycles, `en`=1 → `valid` once every 1000 cycles with `high_cnt`=300 and `period_cnt`=1000, 3-cycle latency from the input edge.
- **Servo pulse:** high 187_500 / period 2_500_000 (1.5 ms / 20 ms at 125 MHz) → `high_cnt`=187_500, `period_cnt`=2_500_000, `timeout`=0.
- **Stuck input:**
  - Hold `pwm_in`=1 → `timeout`=1 and `level`=1 exactly `TIMEOUT_CYC` cycles after the last `rise`. No `valid`.
  - Resume toggling → `timeout` clears on the first `rise`, and the first `valid` comes one period later.
- **Narrowest waveform:** high 1 / period 2 → `high_cnt`=1, `period_cnt`=2 every 2 cycles.
- **Enable drop:** `en`=0 during HIGH → state IDLE, results held, no `valid`. `en`=1 → first `valid` after two rises.
